// File: rtl/traffic_light_param_if.sv
// Signal bundle between the intersection controller and its environment
// (sensors/requests in, lamp drives and display countdown out).
interface traffic_light_param_if #(
  parameter int CW = 4
);
  logic          sensor;
  logic          walk_btn;
  logic          night_mode;
  logic [2:0]    main_rgy;
  logic [2:0]    side_rgy;
  logic          walk_light;
  logic [CW-1:0] remaining;
  logic [3:0]    state_o;

  modport master (
    output sensor, walk_btn, night_mode,
    input  main_rgy, side_rgy, walk_light, remaining, state_o
  );

  modport slave (
    input  sensor, walk_btn, night_mode,
    output main_rgy, side_rgy, walk_light, remaining, state_o
  );
endinterface

// File: rtl/traffic_light_param.sv
// Main/side intersection controller: timed phases, sensor extension, pedestrian
// all-red walk phase and night flashing; lamps are a Moore decode of the state.
module traffic_light_param #(
  parameter int CW       = 4,
  parameter int T_MAIN_G = 6,
  parameter int T_SIDE_G = 6,
  parameter int T_EXT    = 3,
  parameter int T_Y      = 2,
  parameter int T_WALK   = 3,
  parameter int T_AR     = 1
) (
  input  logic                 slow_clk,
  input  logic                 rst,
  traffic_light_param_if.slave tl
);

  typedef enum logic [3:0] {
    ALLRED = 4'd0,
    MG     = 4'd1,
    MG_EXT = 4'd2,
    MY     = 4'd3,
    WALK   = 4'd4,
    SG     = 4'd5,
    SG_EXT = 4'd6,
    SY     = 4'd7,
    NIGHT  = 4'd8
  } state_t;

  localparam logic [CW-1:0] L_MG   = CW'(T_MAIN_G - 1);
  localparam logic [CW-1:0] L_SG   = CW'(T_SIDE_G - 1);
  localparam logic [CW-1:0] L_EXT  = CW'(T_EXT - 1);
  localparam logic [CW-1:0] L_Y    = CW'(T_Y - 1);
  localparam logic [CW-1:0] L_WALK = CW'(T_WALK - 1);
  localparam logic [CW-1:0] L_AR   = CW'(T_AR - 1);

  state_t        state, state_n;
  logic [CW-1:0] timer, timer_n;
  logic          walk_pend, flash;
  logic          tdone;

  function automatic logic [CW-1:0] load_val(input state_t s);
    case (s)
      MG:             load_val = L_MG;
      SG:             load_val = L_SG;
      MG_EXT, SG_EXT: load_val = L_EXT;
      MY, SY:         load_val = L_Y;
      WALK:           load_val = L_WALK;
      ALLRED:         load_val = L_AR;
      default:        load_val = '0;
    endcase
  endfunction

  assign tdone = (timer == '0);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state     <= ALLRED;
      timer     <= L_AR;
      walk_pend <= 1'b0;
      flash     <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      // A press on the edge that enters WALK is absorbed by that walk phase.
      walk_pend <= (state_n == WALK && state != WALK) ? 1'b0 : (walk_pend | tl.walk_btn);
      if (state_n == NIGHT)
        flash <= (state != NIGHT) ? 1'b1 : ~flash;
      else
        flash <= 1'b0;
    end
  end

  always_comb begin
    state_n       = state;
    tl.main_rgy   = 3'b100;
    tl.side_rgy   = 3'b100;
    tl.walk_light = 1'b0;
    case (state)
      ALLRED: if (tdone) state_n = MG;
      MG: begin
        tl.main_rgy = 3'b001;
        if (tdone) state_n = tl.night_mode ? MY : (tl.sensor ? MG_EXT : MY);
      end
      MG_EXT: begin
        tl.main_rgy = 3'b001;
        if (tdone) state_n = MY;
      end
      MY: begin
        tl.main_rgy = 3'b010;
        if (tdone) state_n = tl.night_mode ? NIGHT : (walk_pend ? WALK : SG);
      end
      WALK: begin
        tl.walk_light = 1'b1;
        if (tdone) state_n = SG;
      end
      SG: begin
        tl.side_rgy = 3'b001;
        if (tdone) state_n = (tl.sensor && !tl.night_mode) ? SG_EXT : SY;
      end
      SG_EXT: begin
        tl.side_rgy = 3'b001;
        if (tdone) state_n = SY;
      end
      SY: begin
        tl.side_rgy = 3'b010;
        if (tdone) state_n = tl.night_mode ? NIGHT : MG;
      end
      NIGHT: begin
        tl.main_rgy = {1'b0, flash, 1'b0};
        tl.side_rgy = {flash, 2'b00};
        if (!tl.night_mode) state_n = ALLRED;
      end
      default: state_n = ALLRED;
    endcase

    // Reload on every phase change; NIGHT is untimed and parks the timer at 0.
    if (state_n != state)
      timer_n = load_val(state_n);
    else if (!tdone)
      timer_n = timer - 1'b1;
    else
      timer_n = timer;
  end

  assign tl.remaining = timer;
  assign tl.state_o   = state;

endmodule

// File: tb/tb_traffic_light_param.sv
// Randomised bench for traffic_light_param against a phase/age reference model.
module tb_traffic_light_param;

  localparam int CW = 4;
  localparam int N_CYC = 4000;

  logic slow_clk = 1'b0;
  logic rst;

  traffic_light_param_if #(.CW(CW)) bus ();

  traffic_light_param #(
    .CW(CW), .T_MAIN_G(6), .T_SIDE_G(6), .T_EXT(3), .T_Y(2), .T_WALK(3), .T_AR(1)
  ) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .tl       (bus.slave)
  );

  always #5 slow_clk = ~slow_clk;

  typedef enum {P_AR, P_MG, P_MGX, P_MY, P_WALK, P_SG, P_SGX, P_SY, P_NIGHT} ph_t;

  int  total = 0;
  int  bad   = 0;
  ph_t ph;
  int  age;
  bit  pend, flash_m;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur(input ph_t p);
    case (p)
      P_MG, P_SG:   return 6;
      P_MGX, P_SGX: return 3;
      P_MY, P_SY:   return 2;
      P_WALK:       return 3;
      default:      return 1;
    endcase
  endfunction

  task automatic model_reset();
    ph = P_AR; age = 0; pend = 0; flash_m = 0;
  endtask

  task automatic model_step(input bit sen, input bit wb, input bit nm);
    ph_t nxt;
    nxt = ph;
    if (ph == P_NIGHT) begin
      if (!nm) nxt = P_AR;
    end else if (age == dur(ph) - 1) begin
      case (ph)
        P_AR:   nxt = P_MG;
        P_MG:   nxt = (!nm && sen) ? P_MGX : P_MY;
        P_MGX:  nxt = P_MY;
        P_MY:   nxt = nm ? P_NIGHT : (pend ? P_WALK : P_SG);
        P_WALK: nxt = P_SG;
        P_SG:   nxt = (sen && !nm) ? P_SGX : P_SY;
        P_SGX:  nxt = P_SY;
        P_SY:   nxt = nm ? P_NIGHT : P_MG;
        default: nxt = P_AR;
      endcase
    end
    pend    = (nxt == P_WALK && ph != P_WALK) ? 1'b0 : (pend | wb);
    flash_m = (nxt == P_NIGHT) ? ((ph != P_NIGHT) ? 1'b1 : !flash_m) : 1'b0;
    age     = (nxt != ph) ? 0 : age + 1;
    ph      = nxt;
  endtask

  task automatic check_all(input string tag);
    int m, s;
    case (ph)
      P_MG, P_MGX: begin m = 1; s = 4; end
      P_MY:        begin m = 2; s = 4; end
      P_SG, P_SGX: begin m = 4; s = 1; end
      P_SY:        begin m = 4; s = 2; end
      P_NIGHT:     begin m = flash_m ? 2 : 0; s = flash_m ? 4 : 0; end
      default:     begin m = 4; s = 4; end
    endcase
    chk({tag, ".main"}, int'(bus.main_rgy), m);
    chk({tag, ".side"}, int'(bus.side_rgy), s);
    chk({tag, ".walk"}, int'(bus.walk_light), (ph == P_WALK) ? 1 : 0);
    chk({tag, ".rem"},  int'(bus.remaining), (ph == P_NIGHT) ? 0 : dur(ph) - 1 - age);
  endtask

  initial begin
    bit nm_state;
    rst = 1'b1;
    bus.sensor = 1'b0; bus.walk_btn = 1'b0; bus.night_mode = 1'b0;
    nm_state = 1'b0;
    model_reset();
    repeat (2) @(negedge slow_clk);
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < N_CYC; i++) begin
      check_all("run");
      if (i == 1000 || (i > 50 && $urandom_range(0, 299) == 0)) begin
        // Async reset between edges must take effect without waiting for a clock.
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge slow_clk);
        check_all("rst_hold");
        rst = 1'b0;
      end
      if (i < 20) begin
        bus.sensor = 1'b0; bus.walk_btn = 1'b0; bus.night_mode = 1'b0;
      end else begin
        if ($urandom_range(0, 59) == 0) nm_state = !nm_state;
        bus.sensor     = ($urandom_range(0, 1) == 1);
        bus.walk_btn   = ($urandom_range(0, 19) == 0);
        bus.night_mode = nm_state;
      end
      @(posedge slow_clk);
      model_step(bus.sensor, bus.walk_btn, bus.night_mode);
      @(negedge slow_clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
